// File: rtl/da_bitserial_ctrl.sv
// Bit-serial sequencer for the distributed-arithmetic LUT / shift-accumulate datapath.
// Streams one K-element activation vector LSB first, waits out the pipeline, then hands off the result.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | no job; start_ready=1
//  S_RUN   | one bit beat per cycle on gen_done/A0/addr_array/t
//  S_DRAIN | waiting PIPE_LAT cycles for the accumulator to settle
//  S_HOLD  | out_valid=1 until out_ready; may accept the next job directly
module da_bitserial_ctrl #(
    parameter int DATA_WIDTH_A = 16,
    parameter int K            = 9,
    parameter int PIPE_LAT     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      start_ready,
    input  logic [K*DATA_WIDTH_A-1:0] a_vec,
    output logic                      gen_done,
    output logic                      A0,
    output logic [K-2:0]              addr_array,
    output logic [7:0]                t,
    output logic                      acc_clr,
    output logic                      sign_step,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [7:0] T_LAST     = 8'(DATA_WIDTH_A - 1);
    localparam logic [3:0] DRAIN_INIT = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;

    state_t                    state_q, state_d;
    logic [7:0]                t_q, t_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH_A-1:0]   sreg_q [K];
    logic [DATA_WIDTH_A-1:0]   sreg_d [K];
    logic                      gen_q, gen_d;
    logic                      a0_q, a0_d;
    logic [K-2:0]              addr_q, addr_d;
    logic                      clr_q, clr_d;
    logic                      sign_q, sign_d;

    logic [DATA_WIDTH_A-1:0]   a_el [K];
    logic [K-1:0]              beat_bits;
    logic                      accept;

    for (genvar g = 0; g < K; g++) begin : g_slice
        assign a_el[g] = a_vec[g*DATA_WIDTH_A +: DATA_WIDTH_A];
    end

    assign start_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
    assign accept      = start & start_ready;

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        gen_d     = 1'b0;
        a0_d      = 1'b0;
        addr_d    = '0;
        clr_d     = 1'b0;
        sign_d    = 1'b0;
        beat_bits = '0;

        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                if (t_q == T_LAST) begin
                    state_d = (PIPE_LAT == 0) ? S_HOLD : S_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end else begin
                    // register holds a >> (t+1), so bit 0 is the next beat
                    for (int i = 0; i < K; i++) begin
                        beat_bits[i] = sreg_q[i][0];
                        sreg_d[i]    = sreg_q[i] >> 1;
                    end
                    t_d    = t_q + 8'd1;
                    gen_d  = 1'b1;
                    sign_d = ((t_q + 8'd1) == T_LAST);
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The t=0 beat is formed straight from a_vec so it appears one cycle after accept.
        if (accept) begin
            state_d = S_RUN;
            t_d     = 8'd0;
            for (int i = 0; i < K; i++) begin
                beat_bits[i] = a_el[i][0];
                sreg_d[i]    = a_el[i] >> 1;
            end
            gen_d  = 1'b1;
            clr_d  = 1'b1;
            sign_d = (T_LAST == 8'd0);
        end

        if (gen_d) begin
            a0_d = beat_bits[0];
            for (int j = 0; j < K - 1; j++) begin
                addr_d[j] = ~(beat_bits[j+1] ^ beat_bits[0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            gen_q   <= 1'b0;
            a0_q    <= 1'b0;
            addr_q  <= '0;
            clr_q   <= 1'b0;
            sign_q  <= 1'b0;
            for (int i = 0; i < K; i++) begin
                sreg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            gen_q   <= gen_d;
            a0_q    <= a0_d;
            addr_q  <= addr_d;
            clr_q   <= clr_d;
            sign_q  <= sign_d;
            sreg_q  <= sreg_d;
        end
    end

    assign gen_done   = gen_q;
    assign A0         = a0_q;
    assign addr_array = addr_q;
    assign t          = t_q;
    assign acc_clr    = clr_q;
    assign sign_step  = sign_q;
    assign out_valid  = (state_q == S_HOLD);
    assign busy       = (state_q != S_IDLE);

endmodule
